vram_arbiter: RTL



---
 rtl/zx_mem_pkg.sv | 26 ++
 rtl/vram_slot_pipe.sv | 44 ++++
 rtl/vram_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/zx_mem_pkg.sv
`default_nettype none
// ============================================================================
// zx_mem_pkg
// Shared widths, RAM slot tags and CPU tracker states for the VRAM arbiter.
// Revision: 1.0
// ============================================================================
package zx_mem_pkg;

    localparam int unsigned c_VRAM_ADDR_W = 13;
    localparam int unsigned c_VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        SLOT_NONE   = 2'd0,
        SLOT_VID    = 2'd1,
        SLOT_CPU_RD = 2'd2,
        SLOT_CPU_WR = 2'd3
    } slot_tag_e;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_PEND = 2'd1,
        CPU_DONE = 2'd2
    } cpu_state_e;

endpackage
`default_nettype wire

// File: rtl/vram_slot_pipe.sv
`default_nettype none
// ============================================================================
// vram_slot_pipe
// Two-stage tag shift following each RAM slot to its read-data cycle.
// Revision: 1.0
// ============================================================================
module vram_slot_pipe
    import zx_mem_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  slot_tag_e slot_in,
    output logic      vid_valid,
    output logic      cpu_capture,
    output logic      cpu_rd_inflight
);

    slot_tag_e stage1_q;
    slot_tag_e stage1_d;
    slot_tag_e stage2_q;
    slot_tag_e stage2_d;

    // stage1 = slot on the RAM bus, stage2 = cycle its ram_dout is valid
    always_comb begin
        stage1_d = slot_in;
        stage2_d = stage1_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage1_q <= SLOT_NONE;
            stage2_q <= SLOT_NONE;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign vid_valid       = resetn & (stage2_q == SLOT_VID);
    assign cpu_capture     = resetn & (stage2_q == SLOT_CPU_RD);
    assign cpu_rd_inflight = (stage1_q == SLOT_CPU_RD) | (stage2_q == SLOT_CPU_RD);

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// vram_arbiter
// Single-port VRAM shared by the Z80 bus and the pixel fetcher, video first.
// Revision: 1.0
// ============================================================================
module vram_arbiter
    import zx_mem_pkg::*;
#(
    parameter int unsigned ADDR_W        = c_VRAM_ADDR_W,
    parameter int unsigned DATA_W        = c_VRAM_DATA_W,
    parameter int unsigned MAX_VID_BURST = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_sel,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned           c_BURST_W   = 4;
    localparam logic [c_BURST_W-1:0]  c_BURST_MAX = c_BURST_W'(MAX_VID_BURST);

    cpu_state_e           state_q,   state_d;
    logic [c_BURST_W-1:0] burst_q,   burst_d;
    logic                 ram_ce_q,  ram_ce_d;
    logic                 ram_wre_q, ram_wre_d;
    logic [ADDR_W-1:0]    ram_ad_q,  ram_ad_d;
    logic [DATA_W-1:0]    ram_din_q, ram_din_d;
    logic [DATA_W-1:0]    rdata_q,   rdata_d;
    slot_tag_e            w_slot_tag;

    logic w_cpu_req;
    logic w_cpu_active;
    logic w_cpu_elig;
    logic w_burst_full;
    logic w_cpu_gnt;
    logic w_vid_gnt;
    logic w_cpu_capture;
    logic w_cpu_rd_inflight;

    assign w_cpu_req    = cpu_sel & (cpu_rd | cpu_wr);
    assign w_cpu_active = resetn & ((state_q == CPU_PEND) |
                                    ((state_q == CPU_IDLE) & w_cpu_req));
    // An aborted (deselected) cycle or a read still in the pipe never issues a slot
    assign w_cpu_elig   = resetn & w_cpu_req & (state_q != CPU_DONE) & ~w_cpu_rd_inflight;
    assign w_burst_full = (burst_q == c_BURST_MAX);
    assign w_cpu_gnt    = w_cpu_elig & (~vid_req | w_burst_full);
    assign w_vid_gnt    = resetn & vid_req & ~(w_cpu_elig & w_burst_full);

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        ram_ce_d   = 1'b0;
        ram_wre_d  = 1'b0;
        ram_ad_d   = ram_ad_q;
        ram_din_d  = ram_din_q;
        rdata_d    = rdata_q;
        w_slot_tag = SLOT_NONE;

        if (w_cpu_gnt) begin
            ram_ce_d = 1'b1;
            ram_ad_d = cpu_addr;
            if (cpu_wr) begin
                ram_wre_d  = 1'b1;
                ram_din_d  = cpu_wdata;
                w_slot_tag = SLOT_CPU_WR;
            end else begin
                w_slot_tag = SLOT_CPU_RD;
            end
        end else if (w_vid_gnt) begin
            ram_ce_d   = 1'b1;
            ram_ad_d   = vid_addr;
            w_slot_tag = SLOT_VID;
        end

        if (w_cpu_gnt || !w_cpu_elig) begin
            burst_d = '0;
        end else if (w_vid_gnt && !w_burst_full) begin
            burst_d = burst_q + c_BURST_W'(1);
        end

        if (w_cpu_capture) begin
            rdata_d = ram_dout;
        end

        case (state_q)
            CPU_IDLE: begin
                if (w_cpu_req) begin
                    state_d = (w_cpu_gnt && cpu_wr) ? CPU_DONE : CPU_PEND;
                end
            end
            CPU_PEND: begin
                if (!cpu_sel) begin
                    state_d = CPU_IDLE;
                end else if ((w_cpu_gnt && cpu_wr) || w_cpu_capture) begin
                    state_d = CPU_DONE;
                end
            end
            CPU_DONE: begin
                if (!cpu_sel) begin
                    state_d = CPU_IDLE;
                end
            end
            default: state_d = CPU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= CPU_IDLE;
            burst_q   <= '0;
            ram_ce_q  <= 1'b0;
            ram_wre_q <= 1'b0;
            ram_ad_q  <= '0;
            ram_din_q <= '0;
            rdata_q   <= {DATA_W{1'b1}};
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            ram_ce_q  <= ram_ce_d;
            ram_wre_q <= ram_wre_d;
            ram_ad_q  <= ram_ad_d;
            ram_din_q <= ram_din_d;
            rdata_q   <= rdata_d;
        end
    end

    vram_slot_pipe u_slot_pipe (
        .clk             (clk),
        .resetn          (resetn),
        .slot_in         (w_slot_tag),
        .vid_valid       (vid_valid),
        .cpu_capture     (w_cpu_capture),
        .cpu_rd_inflight (w_cpu_rd_inflight)
    );

    assign vid_gnt    = w_vid_gnt;
    assign cpu_wait_n = ~w_cpu_active;
    assign cpu_rdata  = rdata_q;
    assign vid_data   = ram_dout;
    assign ram_ce     = ram_ce_q;
    assign ram_wre    = ram_wre_q;
    assign ram_ad     = ram_ad_q;
    assign ram_din    = ram_din_q;

endmodule
`default_nettype wire
